// File: rtl/mem_arbiter.sv
// Arbiter for one single-port memory shared by instruction fetch (IF) and data access (DM).
// Fixed DM-over-IF priority, one access in flight, cancellable fetches, and a timeout watchdog.
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_cancel,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_stall,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        dm_stall,
   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ready,
   output logic        err,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   // Handshake: m_req stays high from grant until the cycle m_ready is high (or the
   // watchdog fires); m_* payload is frozen for that whole period. A requester's
   // *_valid is a single-cycle pulse in the completion cycle; *_req must then be
   // held stable while its *_stall is high.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           drop_q, drop_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
   logic           m_we_q, m_we_d;
   logic [3:0]     m_be_q, m_be_d;
   logic [31:0]    m_addr_q, m_addr_d;
   logic [31:0]    m_wdata_q, m_wdata_d;

   logic busy;
   logic timeout_hit;
   logic done;

   always_comb begin
      busy        = (state_q != IDLE);
      timeout_hit = busy & ~m_ready & (cnt_q == CW'(TIMEOUT - 1));
      done        = busy & (m_ready | timeout_hit);

      // A cancel arriving in the completion cycle itself also suppresses the stale fetch.
      if_valid = (state_q == IF_BUSY) & done & ~(drop_q | if_cancel);
      dm_valid = (state_q == DM_BUSY) & done;
      if_rdata = (if_valid & m_ready) ? m_rdata : 32'h0;
      dm_rdata = (dm_valid & m_ready) ? m_rdata : 32'h0;
      if_stall = if_req & ~if_valid;
      dm_stall = dm_req & ~dm_valid;

      m_req     = busy;
      m_we      = m_we_q;
      m_be      = m_be_q;
      m_addr    = m_addr_q;
      m_wdata   = m_wdata_q;
      err       = err_q;
      dbg_state = state_q;
   end

   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      m_we_d    = m_we_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            drop_d = 1'b0;
            if (dm_req) begin
               state_d   = DM_BUSY;
               m_we_d    = dm_we;
               m_be_d    = dm_we ? dm_be : 4'hF;
               m_addr_d  = dm_addr;
               m_wdata_d = dm_wdata;
            end else if (if_req && !if_cancel) begin
               state_d   = IF_BUSY;
               m_we_d    = 1'b0;
               m_be_d    = 4'hF;
               m_addr_d  = if_addr;
               m_wdata_d = 32'h0;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (done) begin
               state_d = IDLE;
               drop_d  = 1'b0;
               cnt_d   = '0;
               err_d   = err_q | timeout_hit;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (state_q == IF_BUSY && if_cancel) drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         drop_q    <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         m_we_q    <= 1'b0;
         m_be_q    <= 4'h0;
         m_addr_q  <= 32'h0;
         m_wdata_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         m_we_q    <= m_we_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder model, a request/response scoreboard
// and a directed sequence covering fetch, contention, cancel, timeout, async reset and back-to-back loads.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid, dm_stall;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ready;
  logic        err;
  logic [1:0]  dbg_state;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];

  int checks = 0;
  int errors = 0;

  int          lat = 0;
  logic [31:0] mem_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
    exp_req_q.push_back(r);
  endtask

  // ---------------- memory responder ----------------
  // Raises m_ready in the lat-th cycle of m_req; lat==0 never answers.
  int busy_cnt = 0;
  initial begin
    m_ready = 1'b0;
    m_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #2;
      if (m_req) begin
        busy_cnt++;
        if (lat != 0 && busy_cnt == lat) begin
          m_ready = 1'b1;
          m_rdata = mem_data;
        end else begin
          m_ready = 1'b0;
          m_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        busy_cnt = 0;
        m_ready  = 1'b0;
        m_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- monitors ----------------
  logic req_prev = 1'b0;
  req_t held;
  initial forever begin
    @(negedge clk);
    if (m_req && !req_prev) begin
      if (exp_req_q.size() == 0) chk("m_req_unexpected", {31'h0, m_req}, 32'h0);
      else begin
        held = exp_req_q.pop_front();
        chk("m_we", {31'h0, m_we}, {31'h0, held.we});
        chk("m_be", {28'h0, m_be}, {28'h0, held.be});
        chk("m_addr", m_addr, held.addr);
        if (held.we) chk("m_wdata", m_wdata, held.wdata);
      end
    end else if (m_req) begin
      chk("m_addr_stable", m_addr, held.addr);
      chk("m_ctl_stable", {27'h0, m_we, m_be}, {27'h0, held.we, held.be});
    end
    req_prev = m_req;
  end

  initial forever begin
    @(negedge clk);
    if (if_valid) begin
      if (exp_if_q.size() == 0) chk("if_valid_unexpected", {31'h0, if_valid}, 32'h0);
      else chk("if_rdata", if_rdata, exp_if_q.pop_front());
    end else chk("if_rdata_zero", if_rdata, 32'h0);
    if (dm_valid) begin
      if (exp_dm_q.size() == 0) chk("dm_valid_unexpected", {31'h0, dm_valid}, 32'h0);
      else chk("dm_rdata", dm_rdata, exp_dm_q.pop_front());
    end else chk("dm_rdata_zero", dm_rdata, 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the chosen valid; counts stall cycles before it and m_req cycles.
  task automatic wait_valid(input bit dm, input int limit, output int stalls,
                            output int vcyc, output int reqcyc);
    stalls = 0;
    reqcyc = 0;
    vcyc   = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m_req) reqcyc++;
      if (dm ? dm_valid : if_valid) begin
        vcyc = cyc;
        chk("stall_low_at_valid", {31'h0, dm ? dm_stall : if_stall}, 32'h0);
        break;
      end
      if (dm ? dm_stall : if_stall) stalls++;
    end
    chk("valid_seen", {31'h0, vcyc >= 0}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int st, vc, rc, t0, vc1, vc2;
  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_cancel = 0;
    dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    tick(2);
    chk("rst_m_req", {31'h0, m_req}, 32'h0);
    chk("rst_m_ctl", {27'h0, m_we, m_be}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_valids", {30'h0, if_valid, dm_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b0;
    tick(1);

    // Single fetch, memory answers in 2nd m_req cycle.
    lat = 2; mem_data = 32'h2008_0005; if_addr = 32'h0000_0040;
    push_req(1'b0, 4'hF, 32'h40, 32'h0);
    exp_if_q.push_back(32'h2008_0005);
    if_req = 1; t0 = cyc;
    wait_valid(1'b0, 20, st, vc, rc);
    if_req = 0;
    chk("fetch_stall_cycles", st, 2);
    chk("fetch_latency", vc - t0, 2);
    tick(2);

    // Contention: DM store first, one IDLE cycle, then the fetch.
    lat = 1; mem_data = 32'h1234_5678;
    dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hABCD; if_addr = 32'h44;
    push_req(1'b1, 4'b0011, 32'h100, 32'hABCD);
    push_req(1'b0, 4'hF, 32'h44, 32'h0);
    exp_dm_q.push_back(32'h1234_5678);
    exp_if_q.push_back(32'h1234_5678);
    dm_req = 1; if_req = 1;
    wait_valid(1'b1, 20, st, vc, rc);
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    chk("contention_gap_idle", {31'h0, m_req}, 32'h0);
    @(posedge clk); #1;
    wait_valid(1'b0, 20, st, vc, rc);
    if_req = 0;
    tick(2);

    // Cancel in flight: grant at g, cancel at g+1, m_ready at g+2.
    lat = 3; mem_data = 32'h0BAD_0BAD; if_addr = 32'h48;
    push_req(1'b0, 4'hF, 32'h48, 32'h0);
    if_req = 1;
    tick(1);
    tick(1);
    if_cancel = 1; if_req = 0;
    tick(1);
    if_cancel = 0;
    @(negedge clk);
    chk("cancel_m_req_held", {31'h0, m_req}, 32'h1);
    chk("cancel_no_valid", {31'h0, if_valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cancel_then_idle", {31'h0, m_req}, 32'h0);
    @(posedge clk); #1;

    // Timeout: DM load, memory never answers.
    lat = 0;
    chk("err_before_timeout", {31'h0, err}, 32'h0);
    dm_we = 0; dm_be = 4'b0101; dm_addr = 32'h200; dm_wdata = 32'h55;
    push_req(1'b0, 4'hF, 32'h200, 32'h0);
    exp_dm_q.push_back(32'h0);
    dm_req = 1;
    wait_valid(1'b1, 20, st, vc, rc);
    dm_req = 0;
    chk("timeout_m_req_cycles", rc, TO);
    @(negedge clk);
    chk("timeout_err_set", {31'h0, err}, 32'h1);
    chk("timeout_m_req_low", {31'h0, m_req}, 32'h0);
    @(posedge clk); #1;

    // Back-to-back loads with dm_req held, 1-cycle memory latency.
    lat = 1; dm_addr = 32'h300; mem_data = 32'hA0A0_0001;
    push_req(1'b0, 4'hF, 32'h300, 32'h0);
    exp_dm_q.push_back(32'hA0A0_0001);
    dm_req = 1; t0 = cyc;
    wait_valid(1'b1, 20, st, vc1, rc);
    dm_addr = 32'h304; mem_data = 32'hB0B0_0002;
    push_req(1'b0, 4'hF, 32'h304, 32'h0);
    exp_dm_q.push_back(32'hB0B0_0002);
    wait_valid(1'b1, 20, st, vc2, rc);
    dm_req = 0;
    chk("b2b_first_valid", vc1 - t0, 1);
    chk("b2b_second_valid", vc2 - t0, 3);
    chk("err_sticky", {31'h0, err}, 32'h1);
    tick(2);

    // Async reset while DM_BUSY.
    lat = 0; dm_addr = 32'h400;
    push_req(1'b0, 4'hF, 32'h400, 32'h0);
    dm_req = 1;
    tick(1);
    @(negedge clk);
    chk("pre_reset_busy", {31'h0, m_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_m_req", {31'h0, m_req}, 32'h0);
    chk("async_dm_valid", {31'h0, dm_valid}, 32'h0);
    chk("async_err", {31'h0, err}, 32'h0);
    dm_req = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    tick(3);
    lat = 1; if_addr = 32'h80; mem_data = 32'h1357_9BDF;
    push_req(1'b0, 4'hF, 32'h80, 32'h0);
    exp_if_q.push_back(32'h1357_9BDF);
    if_req = 1;
    wait_valid(1'b0, 20, st, vc, rc);
    if_req = 0;
    tick(3);

    chk("req_q_drained", exp_req_q.size(), 32'h0);
    chk("if_q_drained", exp_if_q.size(), 32'h0);
    chk("dm_q_drained", exp_dm_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
